// File: rtl/csr_mtrap_unit.sv
// csr_mtrap_unit: machine-mode CSR file, cycle/instret counters and trap controller.
// CSR reads and trap decisions are combinational; architectural state changes on the rising edge.
module csr_mtrap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     HART_ID     = 0,
  parameter int unsigned     CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_en,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_retire,
  input  logic            i_ex_illegal,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_irq_sw,
  input  logic            i_irq_timer,
  input  logic            i_irq_ext,
  output logic [XLEN-1:0] o_rd,
  output logic            o_trap,
  output logic            o_eret,
  output logic [XLEN-1:0] o_tvec,
  output logic [XLEN-1:0] o_epc,
  output logic            o_illegal_csr
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTIH = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRTH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] ADDR_MRET     = 12'h302;

  localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h100);
  localparam logic [XLEN-1:0] IRQ_FLAG = {1'b1, {(XLEN-1){1'b0}}};

  // Architectural state
  logic            st_mie, st_mpie;
  logic            ie_sw, ie_timer, ie_ext;
  logic [XLEN-1:2] tvec_base;
  logic [1:0]      tvec_mode;
  logic [XLEN-1:0] mscratch, mepc, mcause, mtval;
  logic            inh_cy, inh_ir;
  logic [CNT_W-1:0] mcycle, minstret;

  // Instruction decode
  logic [2:0]  f3;
  logic [11:0] addr;
  logic [4:0]  rs1;
  logic        sys0, is_ecall, is_ebreak, is_mret;
  logic        csr_access, wr_req, do_write;
  logic [XLEN-1:0] src, wval, rd;
  logic        implemented, illegal_csr;

  assign f3   = i_inst[14:12];
  assign addr = i_inst[31:20];
  assign rs1  = i_inst[19:15];

  assign sys0       = i_csr_en && (f3 == 3'd0);
  assign is_ecall   = sys0 && (addr == 12'h000);
  assign is_ebreak  = sys0 && (addr == 12'h001);
  assign is_mret    = sys0 && (addr == ADDR_MRET);
  assign csr_access = i_csr_en && (f3[1:0] != 2'b00);
  // Set/clear with a zero rs1/zimm field is a pure read.
  assign wr_req     = csr_access && ((f3[1:0] == 2'b01) || (rs1 != 5'd0));
  assign src        = f3[2] ? XLEN'(rs1) : i_wd;

  logic [63:0] cyc64, ins64;
  assign cyc64 = 64'(mcycle);
  assign ins64 = 64'(minstret);

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd          = '0;
    implemented = 1'b1;
    case (addr)
      ADDR_MSTATUS: begin
        rd[3]     = st_mie;
        rd[7]     = st_mpie;
        rd[12:11] = 2'b11;
      end
      ADDR_MISA:     rd = MISA_VAL;
      ADDR_MHARTID:  rd = XLEN'(HART_ID);
      ADDR_MIE: begin
        rd[3]  = ie_sw;
        rd[7]  = ie_timer;
        rd[11] = ie_ext;
      end
      ADDR_MTVEC:    rd = {tvec_base, tvec_mode};
      ADDR_MSCRATCH: rd = mscratch;
      ADDR_MEPC:     rd = mepc;
      ADDR_MCAUSE:   rd = mcause;
      ADDR_MTVAL:    rd = mtval;
      ADDR_MIP: begin
        rd[3]  = i_irq_sw;
        rd[7]  = i_irq_timer;
        rd[11] = i_irq_ext;
      end
      ADDR_MCOUNTIH: begin
        rd[0] = inh_cy;
        rd[2] = inh_ir;
      end
      ADDR_MCYCLE:   rd = cyc64[XLEN-1:0];
      ADDR_MINSTRET: rd = ins64[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) rd = XLEN'(cyc64[63:32]);
        else            implemented = 1'b0;
      end
      ADDR_MINSTRTH: begin
        if (XLEN == 32) rd = XLEN'(ins64[63:32]);
        else            implemented = 1'b0;
      end
      default: implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b10:   wval = rd | src;
      2'b11:   wval = rd & ~src;
      default: wval = src;
    endcase
  end

  assign illegal_csr = csr_access &&
                       (!implemented ||
                        (wr_req && (addr[11:10] == 2'b11)) ||
                        (wr_req && (addr == ADDR_MIP)));

  // Trap arbitration: exceptions in fixed priority, then enabled interrupts.
  logic            irq_ext_p, irq_sw_p, irq_timer_p;
  logic            trap, is_irq;
  logic [XLEN-1:0] cause, tval;

  assign irq_ext_p   = st_mie && i_irq_ext   && ie_ext;
  assign irq_sw_p    = st_mie && i_irq_sw    && ie_sw;
  assign irq_timer_p = st_mie && i_irq_timer && ie_timer;

  always_comb begin
    trap   = 1'b1;
    is_irq = 1'b0;
    cause  = '0;
    tval   = '0;
    if (illegal_csr || i_ex_illegal) begin
      cause = XLEN'(2);
      tval  = XLEN'(i_inst);
    end else if (is_ecall) begin
      cause = XLEN'(11);
    end else if (is_ebreak) begin
      cause = XLEN'(3);
      tval  = i_pc;
    end else if (i_ex_inst_addr) begin
      cause = XLEN'(0);
      tval  = i_badaddr;
    end else if (i_ex_ld_addr) begin
      cause = XLEN'(4);
      tval  = i_badaddr;
    end else if (i_ex_st_addr) begin
      cause = XLEN'(6);
      tval  = i_badaddr;
    end else if (irq_ext_p) begin
      is_irq = 1'b1;
      cause  = IRQ_FLAG | XLEN'(11);
    end else if (irq_sw_p) begin
      is_irq = 1'b1;
      cause  = IRQ_FLAG | XLEN'(3);
    end else if (irq_timer_p) begin
      is_irq = 1'b1;
      cause  = IRQ_FLAG | XLEN'(7);
    end else begin
      trap = 1'b0;
    end
  end

  logic eret;
  assign eret     = is_mret && !trap;
  assign do_write = wr_req && !trap;

  logic [XLEN-1:0] tvec_base_addr;
  assign tvec_base_addr = {tvec_base, 2'b00};

  always_comb begin
    o_tvec = tvec_base_addr;
    if (is_irq && VECTORED_EN && (tvec_mode == 2'b01))
      o_tvec = tvec_base_addr + {cause[XLEN-3:0], 2'b00};
  end

  assign o_rd          = rd;
  assign o_trap        = trap;
  assign o_eret        = eret;
  assign o_epc         = {mepc[XLEN-1:2], 2'b00};
  assign o_illegal_csr = illegal_csr;

  // Counter next values; a CSR write to either half replaces the increment for the whole counter.
  logic [63:0]      cyc_wr, ins_wr;
  logic [CNT_W-1:0] cyc_nx, ins_nx;

  always_comb begin
    cyc_wr = cyc64;
    ins_wr = ins64;
    cyc_nx = inh_cy ? mcycle : mcycle + CNT_W'(1);
    ins_nx = (i_retire && !inh_ir) ? minstret + CNT_W'(1) : minstret;
    if (do_write) begin
      case (addr)
        ADDR_MCYCLE: begin
          cyc_wr[XLEN-1:0] = wval;
          cyc_nx = cyc_wr[CNT_W-1:0];
        end
        ADDR_MINSTRET: begin
          ins_wr[XLEN-1:0] = wval;
          ins_nx = ins_wr[CNT_W-1:0];
        end
        ADDR_MCYCLEH: begin
          cyc_wr[63:32] = wval[31:0];
          cyc_nx = cyc_wr[CNT_W-1:0];
        end
        ADDR_MINSTRTH: begin
          ins_wr[63:32] = wval[31:0];
          ins_nx = ins_wr[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_mie    <= 1'b0;
      st_mpie   <= 1'b0;
      ie_sw     <= 1'b0;
      ie_timer  <= 1'b0;
      ie_ext    <= 1'b0;
      tvec_base <= MTVEC_RST[XLEN-1:2];
      tvec_mode <= MTVEC_RST[1:0];
      mscratch  <= '0;
      mepc      <= '0;
      mcause    <= '0;
      mtval     <= '0;
      inh_cy    <= 1'b0;
      inh_ir    <= 1'b0;
      mcycle    <= '0;
      minstret  <= '0;
    end else begin
      mcycle   <= cyc_nx;
      minstret <= ins_nx;
      if (trap) begin
        mepc    <= i_pc;
        mcause  <= cause;
        mtval   <= tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (eret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (do_write) begin
        case (addr)
          ADDR_MSTATUS: begin
            st_mie  <= wval[3];
            st_mpie <= wval[7];
          end
          ADDR_MIE: begin
            ie_sw    <= wval[3];
            ie_timer <= wval[7];
            ie_ext   <= wval[11];
          end
          ADDR_MTVEC: begin
            tvec_base <= wval[XLEN-1:2];
            tvec_mode <= (VECTORED_EN && (wval[1:0] == 2'b01)) ? 2'b01 : 2'b00;
          end
          ADDR_MSCRATCH: mscratch <= wval;
          ADDR_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
          ADDR_MCAUSE:   mcause   <= wval;
          ADDR_MTVAL:    mtval    <= wval;
          ADDR_MCOUNTIH: begin
            inh_cy <= wval[0];
            inh_ir <= wval[2];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// tb_csr_mtrap_unit: directed and randomized stimulus for csr_mtrap_unit (XLEN=32),
// compared each cycle against a behavioural model of the M-mode CSR and trap rules.
module tb_csr_mtrap_unit;

  localparam int unsigned HART = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_en, retire;
  logic [31:0] inst, wd, pc, badaddr;
  logic        ex_illegal, ex_inst, ex_ld, ex_st;
  logic        irq_sw, irq_timer, irq_ext;
  logic [31:0] rd, tvec, epc;
  logic        trap, eret, illegal;

  csr_mtrap_unit #(
    .XLEN(32), .HART_ID(HART), .CNT_W(64), .MTVEC_RST(32'h0), .VECTORED_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_csr_en(csr_en), .i_inst(inst), .i_wd(wd),
    .i_pc(pc), .i_badaddr(badaddr), .i_retire(retire),
    .i_ex_illegal(ex_illegal), .i_ex_inst_addr(ex_inst), .i_ex_ld_addr(ex_ld),
    .i_ex_st_addr(ex_st), .i_irq_sw(irq_sw), .i_irq_timer(irq_timer),
    .i_irq_ext(irq_ext), .o_rd(rd), .o_trap(trap), .o_eret(eret),
    .o_tvec(tvec), .o_epc(epc), .o_illegal_csr(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_inh;
  logic [63:0] m_cyc, m_ins;

  logic [31:0] obs_rd, obs_tvec, obs_epc;
  logic        obs_trap, obs_eret, obs_ill;

  task automatic model_reset;
    m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 0; m_scratch = 0; m_epc = 0;
    m_cause = 0; m_tval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit ok);
    ok = 1'b1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h320: return m_inh;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
      12'hB00: return m_cyc[31:0];
      12'hB02: return m_ins[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB82: return m_ins[63:32];
      12'hF14: return HART;
      default: begin ok = 1'b0; return 32'h0; end
    endcase
  endfunction

  task automatic set_idle;
    csr_en = 0; inst = 32'h0000_0013; wd = 0; pc = 0; badaddr = 0; retire = 0;
    ex_illegal = 0; ex_inst = 0; ex_ld = 0; ex_st = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r);
    return {a, r, f3, 5'd1, 7'h73};
  endfunction

  // One clock cycle: predict, compare away from the edge, clock, then advance the model.
  task automatic step(input string tag);
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  r;
    logic        sys0, is_mret, acc, wr, ill, e_trap, is_irq;
    logic [31:0] cur, src, nv, cause, tval, e_tvec;
    logic [63:0] cyc_old, ins_old;
    bit          ok;
    f3 = inst[14:12]; a = inst[31:20]; r = inst[19:15];
    sys0    = csr_en && (f3 == 3'd0);
    is_mret = sys0 && (a == 12'h302);
    acc     = csr_en && (f3[1:0] != 2'd0);
    cur     = m_read(a, ok);
    src     = f3[2] ? {27'd0, r} : wd;
    wr      = acc && ((f3[1:0] == 2'd1) || (r != 5'd0));
    nv      = (f3[1:0] == 2'd1) ? src : (f3[1:0] == 2'd2) ? (cur | src) : (cur & ~src);
    ill     = acc && (!ok || (wr && a[11:10] == 2'b11) || (wr && a == 12'h344));
    e_trap = 1; is_irq = 0; tval = 0; cause = 0;
    if (ill || ex_illegal)                begin cause = 2; tval = inst; end
    else if (sys0 && a == 12'h000)        cause = 11;
    else if (sys0 && a == 12'h001)        begin cause = 3; tval = pc; end
    else if (ex_inst)                     begin cause = 0; tval = badaddr; end
    else if (ex_ld)                       begin cause = 4; tval = badaddr; end
    else if (ex_st)                       begin cause = 6; tval = badaddr; end
    else if (m_mie && irq_ext && m_ie[11])  begin cause = 32'h8000_000B; is_irq = 1; end
    else if (m_mie && irq_sw && m_ie[3])    begin cause = 32'h8000_0003; is_irq = 1; end
    else if (m_mie && irq_timer && m_ie[7]) begin cause = 32'h8000_0007; is_irq = 1; end
    else e_trap = 0;
    e_tvec = {m_tvec[31:2], 2'b00};
    if (is_irq && m_tvec[1:0] == 2'b01) e_tvec = e_tvec + 4 * (cause & 32'h7FFF_FFFF);

    #3;
    obs_rd = rd; obs_tvec = tvec; obs_epc = epc;
    obs_trap = trap; obs_eret = eret; obs_ill = illegal;
    check({tag, ":trap"}, obs_trap, e_trap);
    check({tag, ":illegal"}, obs_ill, ill);
    check({tag, ":eret"}, obs_eret, is_mret && !e_trap);
    check({tag, ":epc"}, obs_epc, {m_epc[31:2], 2'b00});
    if (e_trap) check({tag, ":tvec"}, obs_tvec, e_tvec);
    if (acc && ok) check({tag, ":rd"}, obs_rd, cur);

    @(posedge clk);
    cyc_old = m_cyc; ins_old = m_ins;
    if (!m_inh[0]) m_cyc = m_cyc + 64'd1;
    if (retire && !m_inh[2]) m_ins = m_ins + 64'd1;
    if (e_trap) begin
      m_epc = pc; m_cause = cause; m_tval = tval; m_mpie = m_mie; m_mie = 0;
    end else if (is_mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (wr) begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_ie = nv & 32'h888;
        12'h305: m_tvec = {nv[31:2], (nv[1:0] == 2'b01) ? 2'b01 : 2'b00};
        12'h320: m_inh = nv & 32'h5;
        12'h340: m_scratch = nv;
        12'h341: m_epc = nv & ~32'h3;
        12'h342: m_cause = nv;
        12'h343: m_tval = nv;
        12'hB00: m_cyc = {cyc_old[63:32], nv};
        12'hB80: m_cyc = {nv, cyc_old[31:0]};
        12'hB02: m_ins = {ins_old[63:32], nv};
        12'hB82: m_ins = {nv, ins_old[31:0]};
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_csr(input string tag, input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] r, input logic [31:0] w);
    set_idle;
    csr_en = 1; inst = mk(f3, a, r); wd = w;
    step(tag);
  endtask

  logic [11:0] addr_tab [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'h320, 12'hB00, 12'hB02,
                                 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h345};
  logic [2:0]  f3_tab [6]    = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    set_idle;
    rst_n = 0;
    model_reset;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("rst:trap", trap, 0);
    check("rst:eret", eret, 0);
    check("rst:illegal", illegal, 0);
    check("rst:epc", epc, 0);
    check("rst:tvec", tvec, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Vectored timer interrupt
    do_csr("t1_tvec", 3'd1, 12'h305, 5'd1, 32'h101);
    do_csr("t1_mstatus", 3'd2, 12'h300, 5'd1, 32'h8);
    do_csr("t1_mie", 3'd2, 12'h304, 5'd1, 32'h80);
    set_idle; pc = 32'h200; irq_timer = 1;
    step("t1_irq");
    check("t1_trap_k", obs_trap, 1);
    check("t1_tvec_k", obs_tvec, 32'h11C);
    do_csr("t1_mepc", 3'd2, 12'h341, 5'd0, 0);
    check("t1_mepc_k", obs_rd, 32'h200);
    do_csr("t1_mcause", 3'd2, 12'h342, 5'd0, 0);
    check("t1_mcause_k", obs_rd, 32'h8000_0007);
    do_csr("t1_mstat", 3'd2, 12'h300, 5'd0, 0);
    check("t1_mstat_k", obs_rd, 32'h1880);

    // MRET from the handler
    set_idle; csr_en = 1; inst = 32'h3020_0073;
    step("t6_mret");
    check("t6_eret_k", obs_eret, 1);
    check("t6_epc_k", obs_epc, 32'h200);
    do_csr("t6_mstat", 3'd2, 12'h300, 5'd0, 0);
    check("t6_mstat_k", obs_rd, 32'h1888);

    // Exception beats simultaneous interrupts and is not vectored
    do_csr("t2_mie", 3'd2, 12'h304, 5'd1, 32'h800);
    set_idle; irq_ext = 1; irq_timer = 1; ex_ld = 1; badaddr = 32'h1003; pc = 32'h300;
    step("t2_exc");
    check("t2_tvec_k", obs_tvec, 32'h100);
    do_csr("t2_mcause", 3'd2, 12'h342, 5'd0, 0);
    check("t2_mcause_k", obs_rd, 32'h4);
    do_csr("t2_mtval", 3'd2, 12'h343, 5'd0, 0);
    check("t2_mtval_k", obs_rd, 32'h1003);

    // Read-only CSR write is illegal; pure read is legal
    do_csr("t3_w", 3'd1, 12'hF14, 5'd1, 32'h55);
    check("t3_ill_k", obs_ill, 1);
    do_csr("t3_mtval", 3'd2, 12'h343, 5'd0, 0);
    check("t3_mtval_k", obs_rd, mk(3'd1, 12'hF14, 5'd1));
    do_csr("t3_r", 3'd2, 12'hF14, 5'd0, 0);
    check("t3_hart_k", obs_rd, HART);

    // 64-bit mcycle wrap and inhibit
    do_csr("t4_lo", 3'd1, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    do_csr("t4_hi", 3'd1, 12'hB80, 5'd1, 32'hFFFF_FFFF);
    set_idle; step("t4_idle");
    do_csr("t4_rlo", 3'd2, 12'hB00, 5'd0, 0);
    check("t4_wrap_lo_k", obs_rd, 0);
    do_csr("t4_rhi", 3'd2, 12'hB80, 5'd0, 0);
    check("t4_wrap_hi_k", obs_rd, 0);
    do_csr("t4_inh", 3'd1, 12'h320, 5'd1, 32'h1);
    do_csr("t4_h1", 3'd2, 12'hB00, 5'd0, 0);
    check("t4_hold1_k", obs_rd, 3);
    do_csr("t4_h2", 3'd2, 12'hB00, 5'd0, 0);
    check("t4_hold2_k", obs_rd, 3);
    do_csr("t4_uninh", 3'd1, 12'h320, 5'd1, 32'h0);

    // Write beats retire increment
    set_idle; csr_en = 1; inst = mk(3'd1, 12'hB02, 5'd1); wd = 5; retire = 1;
    step("t5_w");
    do_csr("t5_r", 3'd2, 12'hB02, 5'd0, 0);
    check("t5_minstret_k", obs_rd, 5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [4:0] r;
      set_idle;
      k = $urandom_range(0, 99);
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (k < 70) begin
        csr_en = 1;
        inst = mk(f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 16)], r);
      end else if (k < 76) begin
        csr_en = 1; inst = 32'h0000_0073;
      end else if (k < 82) begin
        csr_en = 1; inst = 32'h0010_0073;
      end else if (k < 92) begin
        csr_en = 1; inst = 32'h3020_0073;
      end
      wd         = $urandom;
      pc         = $urandom & 32'hFFFF_FFFC;
      badaddr    = $urandom;
      retire     = 1'($urandom_range(0, 1));
      ex_illegal = ($urandom_range(0, 19) == 0);
      ex_inst    = ($urandom_range(0, 19) == 0);
      ex_ld      = ($urandom_range(0, 19) == 0);
      ex_st      = ($urandom_range(0, 19) == 0);
      irq_sw     = ($urandom_range(0, 5) == 0);
      irq_timer  = ($urandom_range(0, 5) == 0);
      irq_ext    = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    // Reset asserted mid-cycle inside a handler aborts the pending write
    do_csr("r_mstat", 3'd1, 12'h300, 5'd1, 32'h8);
    do_csr("r_mie", 3'd1, 12'h304, 5'd1, 32'h888);
    set_idle; irq_timer = 1; pc = 32'h440;
    step("r_irq");
    set_idle; csr_en = 1; inst = mk(3'd1, 12'h340, 5'd1); wd = 32'hDEAD_BEEF; irq_timer = 1;
    #3;
    rst_n = 0;
    model_reset;
    #1;
    check("r_trap_k", trap, 0);
    @(posedge clk); #1;
    set_idle;
    rst_n = 1;
    do_csr("r_scratch", 3'd2, 12'h340, 5'd0, 0);
    check("r_scratch_k", obs_rd, 0);
    do_csr("r_mstatus", 3'd2, 12'h300, 5'd0, 0);
    check("r_mstatus_k", obs_rd, 32'h1800);
    do_csr("r_mepc", 3'd2, 12'h341, 5'd0, 0);
    check("r_mepc_k", obs_rd, 0);
    do_csr("r_mcause", 3'd2, 12'h342, 5'd0, 0);
    check("r_mcause_k", obs_rd, 0);
    do_csr("r_mie_rd", 3'd2, 12'h304, 5'd0, 0);
    check("r_mie_k", obs_rd, 0);
    do_csr("r_mtvec", 3'd2, 12'h305, 5'd0, 0);
    check("r_mtvec_k", obs_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
